alu_dword_ctl: RTL and testbench
================================

ALU_DWORD_CTL -- requirements
Module: alu_dword_ctl

Interface
REQ-001 The block SHALL have one parameter: N, default 32, the word width of the attached generic ALU; operands and result are 2N bits.
REQ-002 Port clk  input  1  the single clock; all state changes on rising edge.
REQ-003 Port rst_n  input  1  reset, synchronous and active-low.
REQ-004 Port req  input  1  operation request, sampled only in IDLE.
REQ-005 Port op  input  2  operation: 00 ADD, 01 SUB, 10 AND, 11 XOR.
REQ-006 Port opa  input  2N  operand A.
REQ-007 Port opb  input  2N  operand B.
REQ-008 Port busy  output  1  high in LO, HI and DONE.
REQ-009 Port done  output  1  one-cycle pulse, result valid.
REQ-010 Port result  output  2N  registered result.
REQ-011 Port carry  output  1  carry out of bit 2N-1 (SUB: 1 = no borrow).
REQ-012 Port ovf  output  1  two's-complement overflow of the 2N-bit op.
REQ-013 Port alu_a  output  N  ALU operand a.
REQ-014 Port alu_b  output  N  ALU operand b.
REQ-015 Port alu_cin  output  1  ALU carry in.
REQ-016 Port alu_m  output  1  ALU mode, 1 arithmetic, 0 logic.
REQ-017 Port alu_s  output  4  ALU function select.
REQ-018 Port alu_out  input  N  ALU result, combinational from the alu_* drives.
REQ-019 Port alu_cout  input  1  ALU carry out.
REQ-020 Port alu_ovf  input  1  ALU overflow.

Function
REQ-021 FSM states SHALL be IDLE, LO, HI, DONE; IDLE->LO on req=1; LO->HI; HI->DONE; DONE->IDLE unconditionally.
REQ-022 On the IDLE->LO edge the block SHALL latch op, opa and opb; opb SHALL be latched inverted when op=SUB.
REQ-023 req while busy=1 SHALL be ignored; no queuing.
REQ-024 ADD/SUB drive: alu_m=1, alu_s=4'd9 (a+b+cin); LO: alu_cin = 1 for SUB, 0 for ADD.
REQ-025 AND drive: alu_m=0, alu_s=4'd14; XOR drive: alu_m=0, alu_s=4'd9; alu_cin=0.
REQ-026 In LO, alu_a/alu_b SHALL be the latched low halves; at the LO->HI edge result[N-1:0] <= alu_out and an internal carry register <= alu_cout (0 for logic ops).
REQ-027 In HI, alu_a/alu_b SHALL be the latched high halves with alu_cin = internal carry register (0 for logic ops); at the HI->DONE edge result[2N-1:N] <= alu_out, carry <= alu_cout, ovf <= alu_ovf.
REQ-028 For AND/XOR, carry and ovf SHALL be captured as 0 regardless of ALU inputs.
REQ-029 In IDLE and DONE the block SHALL drive alu_a=0, alu_b=0, alu_cin=0, alu_m=0, alu_s=4'd0.
REQ-030 done SHALL be 1 exactly in DONE; latency accept edge to done is 3 cycles; next accept possible in the cycle after DONE.
REQ-031 result, carry, ovf SHALL hold their values from DONE until overwritten by the next operation.
REQ-032 Arithmetic SHALL be modulo 2^(2N); carry is bit 2N of the unsigned 2N-bit sum opa + (opb or ~opb) + cin0.

Reset
REQ-033 With rst_n=0 at a rising edge, state SHALL become IDLE and busy, done, result, carry, ovf, the internal carry and latched operands SHALL become 0.
REQ-034 Reset in any state, including mid-operation, SHALL abort the operation with no done pulse; reset dominates req in the same cycle.

Verification (N=32)
REQ-035 ADD opa=0x00000000_FFFFFFFF, opb=1 -> result 0x00000001_00000000, carry 0, ovf 0, done 3 cycles after accept.
REQ-036 SUB opa=0, opb=1 -> result 0xFFFFFFFF_FFFFFFFF, carry 0, ovf 0; LO drives alu_b=0xFFFFFFFE, alu_cin=1.
REQ-037 ADD opa=0x7FFFFFFF_FFFFFFFF, opb=1 -> result 0x80000000_00000000, carry 0, ovf 1; ADD 0xFFFFFFFF_FFFFFFFF+1 -> 0, carry 1, ovf 0.
REQ-038 XOR opa=0xFFFF0000_12345678, opb=0xFFFFFFFF_FFFFFFFF -> result 0x0000FFFF_EDCBA987, carry 0, ovf 0; alu_m=0 in LO and HI.
REQ-039 req held high continuously -> accepts every 4 cycles, one done per accept; req raised during LO/HI/DONE with different operands does not alter the in-flight result.
REQ-040 rst_n=0 for one cycle during HI -> next cycle state IDLE, busy 0, done 0, result 0, carry 0, ovf 0, no done pulse follows.

Source files
------------

// File: rtl/alu_dword_ctl.sv
// rtl/alu_dword_ctl.sv - sequences a 2N-bit ADD/SUB/AND/XOR through an attached N-bit ALU in two halves
module alu_dword_ctl #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req,
  input  logic [1:0]     op,
  input  logic [2*N-1:0] opa,
  input  logic [2*N-1:0] opb,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result,
  output logic           carry,
  output logic           ovf,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic           alu_cin,
  output logic           alu_m,
  output logic [3:0]     alu_s,
  input  logic [N-1:0]   alu_out,
  input  logic           alu_cout,
  input  logic           alu_ovf
);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  localparam logic [3:0] S_SUM = 4'd9;   // a+b+cin in arithmetic mode, a^b in logic mode
  localparam logic [3:0] S_AND = 4'd14;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LO   = 2'b01,
    HI   = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t         state;
  state_t         nxt;
  logic [1:0]     op_q;
  logic [2*N-1:0] a_q;
  logic [2*N-1:0] b_q;    // already inverted for SUB so the ALU only ever adds
  logic           cin_q;  // carry from the low half into the high half
  logic           arith;

  assign arith = (op_q == OP_ADD) || (op_q == OP_SUB);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next state and ALU drive; the ALU sees zeros whenever no half is being computed.
  always_comb begin
    nxt     = state;
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_m   = 1'b0;
    alu_s   = 4'd0;
    case (state)
      IDLE: begin
        if (req) nxt = LO;
      end
      LO: begin
        nxt     = HI;
        alu_a   = a_q[N-1:0];
        alu_b   = b_q[N-1:0];
        alu_m   = arith;
        alu_s   = (op_q == OP_AND) ? S_AND : S_SUM;
        alu_cin = (op_q == OP_SUB);
      end
      HI: begin
        nxt     = DONE;
        alu_a   = a_q[2*N-1:N];
        alu_b   = b_q[2*N-1:N];
        alu_m   = arith;
        alu_s   = (op_q == OP_AND) ? S_AND : S_SUM;
        alu_cin = cin_q;
      end
      DONE: begin
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Operand latch on accept, then capture each half of the result as the ALU produces it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      result <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_q <= op;
            a_q  <= opa;
            b_q  <= (op == OP_SUB) ? ~opb : opb;
          end
        end
        LO: begin
          result[N-1:0] <= alu_out;
          cin_q         <= arith & alu_cout;
        end
        HI: begin
          result[2*N-1:N] <= alu_out;
          carry           <= arith & alu_cout;
          ovf             <= arith & alu_ovf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_dword_ctl.sv
// tb/tb_alu_dword_ctl.sv - scoreboard bench for alu_dword_ctl with a behavioural ALU attached
module tb_alu_dword_ctl;

  localparam int N = 32;
  localparam int W = 2 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [1:0]   op;
  logic [W-1:0] opa;
  logic [W-1:0] opb;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic         alu_cin;
  logic         alu_m;
  logic [3:0]   alu_s;
  logic [N-1:0] alu_out;
  logic         alu_cout;
  logic         alu_ovf;

  alu_dword_ctl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result(result), .carry(carry), .ovf(ovf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_m(alu_m), .alu_s(alu_s),
    .alu_out(alu_out), .alu_cout(alu_cout), .alu_ovf(alu_ovf)
  );

  always #5 clk = ~clk;

  // Generic N-bit ALU: arithmetic mode s=9 adds, logic mode s=14 ANDs and s=9 XORs.
  always_comb begin
    logic [N:0] sum;
    sum      = '0;
    alu_out  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    if (alu_m && alu_s == 4'd9) begin
      sum      = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cin};
      alu_out  = sum[N-1:0];
      alu_cout = sum[N];
      alu_ovf  = (alu_a[N-1] == alu_b[N-1]) && (sum[N-1] != alu_a[N-1]);
    end else if (!alu_m && alu_s == 4'd14) begin
      alu_out = alu_a & alu_b;
    end else if (!alu_m && alu_s == 4'd9) begin
      alu_out = alu_a ^ alu_b;
    end
  end

  typedef struct packed {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         o;
  } exp_t;

  // Whole-width reference: the dword operation done in one step.
  function automatic exp_t ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t       e;
    logic [W:0] full;
    e.op = o; e.a = a; e.b = b; e.c = 1'b0; e.o = 1'b0; e.res = '0;
    full = '0;
    case (o)
      2'b00: begin
        full  = {1'b0, a} + {1'b0, b};
        e.res = full[W-1:0];
        e.c   = full[W];
        e.o   = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      2'b01: begin
        full  = {1'b0, a} + {1'b0, ~b} + 1;
        e.res = full[W-1:0];
        e.c   = full[W];
        e.o   = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
      end
      2'b10: e.res = a & b;
      default: e.res = a ^ b;
    endcase
    return e;
  endfunction

  // Expected occupancy: cycles since accept (0 = idle, 3 = done cycle).
  exp_t         exp_q[$];
  int           phase;
  logic [W-1:0] last_res;
  logic         last_c;
  logic         last_o;

  // Reference timeline: accept when idle, three busy cycles, reset clears everything.
  always @(posedge clk) begin
    if (!rst_n) begin
      phase    <= 0;
      exp_q.delete();
      last_res <= '0;
      last_c   <= 1'b0;
      last_o   <= 1'b0;
    end else begin
      case (phase)
        0: if (req) begin
          exp_q.push_back(ref_op(op, opa, opb));
          phase <= 1;
        end
        1: phase <= 2;
        2: phase <= 3;
        default: begin
          if (exp_q.size() > 0) begin
            last_res <= exp_q[0].res;
            last_c   <= exp_q[0].c;
            last_o   <= exp_q[0].o;
            exp_q.delete(0);
          end
          phase <= 0;
        end
      endcase
    end
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  logic stim_done = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] want);
    n_checks++;
    if (act !== want) $display("FAIL %s actual=%h expected=%h t=%0t", name, act, want, $time);
    else n_pass++;
  endtask

  // Monitor: compares DUT outputs against the reference timeline and scoreboard each cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [W-1:0] beff;
    logic [N:0]   lo_sum;
    logic         ar;
    if (rst_n !== 1'b0 || phase != 0) begin
      chk("busy", {63'd0, busy}, {63'd0, phase != 0});
      chk("done", {63'd0, done}, {63'd0, phase == 3});
    end
    if (phase == 0 || phase == 3) begin
      chk("alu_idle_drive", {alu_a, alu_b}, '0);
      chk("alu_idle_ctl", {58'd0, alu_cin, alu_m, alu_s}, '0);
    end
    if (phase == 0) begin
      chk("held_result", result, last_res);
      chk("held_flags", {62'd0, carry, ovf}, {62'd0, last_c, last_o});
    end else if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 64'd0, 64'd1);
    end else begin
      e      = exp_q[0];
      ar     = !e.op[1];
      beff   = (e.op == 2'b01) ? ~e.b : e.b;
      lo_sum = {1'b0, e.a[N-1:0]} + {1'b0, beff[N-1:0]} + {{N{1'b0}}, e.op == 2'b01};
      if (phase == 1) begin
        chk("lo_ab", {alu_a, alu_b}, {e.a[N-1:0], beff[N-1:0]});
        chk("lo_ctl", {58'd0, alu_cin, alu_m, alu_s},
            {58'd0, e.op == 2'b01, ar, (e.op == 2'b10) ? 4'd14 : 4'd9});
      end else if (phase == 2) begin
        chk("hi_ab", {alu_a, alu_b}, {e.a[W-1:N], beff[W-1:N]});
        chk("hi_ctl", {58'd0, alu_cin, alu_m, alu_s},
            {58'd0, ar & lo_sum[N], ar, (e.op == 2'b10) ? 4'd14 : 4'd9});
      end else begin
        chk("result", result, e.res);
        chk("carry", {63'd0, carry}, {63'd0, e.c});
        chk("ovf", {63'd0, ovf}, {63'd0, e.o});
      end
    end
    if (stim_done) begin
      chk("drained", {32'd0, exp_q.size()}, 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
    end
  end

  function automatic logic [W-1:0] rnd64();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic one_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    req = 1'b1; op = o; opa = a; opb = b;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Stimulus: directed corners, random traffic, held request, and resets mid-flight.
  initial begin
    rst_n = 1'b0; req = 1'b0; op = 2'b00; opa = '0; opb = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    one_op(2'b00, 64'h00000000_FFFFFFFF, 64'h1);
    one_op(2'b01, 64'h0, 64'h1);
    one_op(2'b00, 64'h7FFFFFFF_FFFFFFFF, 64'h1);
    one_op(2'b00, 64'hFFFFFFFF_FFFFFFFF, 64'h1);
    one_op(2'b11, 64'hFFFF0000_12345678, 64'hFFFFFFFF_FFFFFFFF);
    one_op(2'b10, 64'hF0F0F0F0_0F0F0F0F, 64'hFF00FF00_00FF00FF);
    one_op(2'b01, 64'h80000000_00000000, 64'h1);

    for (int i = 0; i < 200; i++) begin
      req = ($urandom_range(0, 2) != 0);
      op  = 2'($urandom_range(0, 3));
      opa = rnd64();
      opb = rnd64();
      @(posedge clk); #1;
    end

    req = 1'b1;
    for (int i = 0; i < 24; i++) begin
      op  = 2'($urandom_range(0, 3));
      opa = rnd64();
      opb = rnd64();
      @(posedge clk); #1;
    end
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    req = 1'b1; op = 2'b00; opa = 64'h12345678_9ABCDEF0; opb = 64'h1;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    one_op(2'b00, 64'h5, 64'h7);
    rst_n = 1'b0; req = 1'b1; op = 2'b11; opa = '1; opb = 64'h3;
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    one_op(2'b01, 64'h1, 64'h2);

    repeat (2) @(posedge clk);
    #1 stim_done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
